readout_sequencer: RTL and testbench
====================================

Name: readout_sequencer

Overview:
Run-level controller for the qubit readout chain (config_params -> timing -> sampler -> multiplier -> integrator). Applies pending configuration only between runs, forwards one external trigger per shot to timing, and watches integrator iq_valid with a timeout. Counts shots and buffers each (i_val, q_val) result in a small FIFO, with a valid/ready handshake to the downstream analysis stage (data dump, binning or classifier).

Parameters:
FIFO_DEPTH, 4, result FIFO entries (power of 2, >=2)
TIMEOUT_CYCLES, 16384, max clk100 cycles from trigger forward to iq_valid

Ports:
clk100  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high
arm  in  1  pulse; start a run of shot_count shots
abort  in  1  pulse; end current run
shot_count  in  16  shots per run, sampled on arm
cfg_req  in  1  level; new config staged on config_params inputs
cfg_ack  out  1  1-cycle pulse when config applied
config_reset  out  1  1-cycle pulse to config_params load input
trigger  in  1  external experiment trigger
timing_trigger  out  1  1-cycle pulse to timing.trigger
iq_valid  in  1  integrator result strobe
i_val  in  32  integrator I
q_val  in  32  integrator Q
res_valid  out  1  FIFO head valid
res_ready  in  1  downstream accepts head
res_i  out  32  head I
res_q  out  32  head Q
res_shot  out  16  shot index of head, 0-based
busy  out  1  state != IDLE
done  out  1  1-cycle pulse at run end
shots_done  out  16  results accepted this run
overflow_err  out  1  sticky; result dropped, FIFO full
timeout_err  out  1  sticky; iq_valid not seen in time

Behaviour:
- Reset: state IDLE. All outputs 0. FIFO emptied; counters and sticky flags cleared.
- States: IDLE, CFG_APPLY, WAIT_TRIG, MEASURE, FINISH.
- IDLE:
  - cfg_req=1 -> CFG_APPLY. cfg_req has priority over a simultaneous arm; that arm is ignored.
  - Otherwise arm=1 -> latch shot_count, clear shots_done and both sticky flags, go to WAIT_TRIG.
  - arm with shot_count=0 -> FINISH directly; no trigger is forwarded.
- CFG_APPLY (1 cycle):
  - config_reset=1 and cfg_ack=1 this cycle; return to IDLE.
  - cfg_req asserted outside IDLE stays pending; it is serviced on the first IDLE cycle.
- WAIT_TRIG:
  - trigger=1 -> timing_trigger=1 next cycle (registered, exactly 1 cycle). Load timeout counter with 0; go to MEASURE.
  - trigger is ignored in every other state.
- MEASURE:
  - Timeout counter increments every cycle.
  - iq_valid=1 -> push {i_val, q_val, shots_done} if FIFO not full, else drop and set overflow_err.
  - On iq_valid, shots_done increments either way (the shot counts as completed). Next state is FINISH if the new shots_done equals the latched count, else WAIT_TRIG.
  - Counter reaching TIMEOUT_CYCLES-1 without iq_valid -> set timeout_err, go to FINISH (run aborted).
  - iq_valid outside MEASURE is ignored (no push).
- FINISH (1 cycle): done=1, then IDLE.
- abort (any non-IDLE state): go to FINISH next cycle. FIFO contents are retained; shots_done is frozen.
- FIFO behaviour:
  - First-word fall-through; res_* stable while res_valid=1 and res_ready=0.
  - Pop on res_valid and res_ready. Push latency: iq_valid at edge N -> res_valid at N+1 when the FIFO was empty.
  - Simultaneous push and pop when full is allowed: not an overflow, occupancy unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - The FIFO drains independently of state, including in IDLE.
- Width rules: shots_done is 16-bit unsigned, no wrap possible (bounded by shot_count); i and q are stored unmodified.
- Reset mid-run: immediate return to IDLE. No done pulse, FIFO flushed.

Decomposition:
- Package readout_pkg:
  - seq_state_t enum (5 states).
  - result_t struct {logic [31:0] i; logic [31:0] q; logic [15:0] shot;}.
  - Width constants SHOT_W=16, IQ_W=32.
- Sub-module result_fifo: parameter DEPTH, result_t data, push/full, pop/valid. Uses the same clk100/reset.

Test Plan:
- Config path: cfg_req=1 in IDLE -> config_reset and cfg_ack high for exactly 1 cycle, 1 cycle later. cfg_req asserted together with arm -> arm ignored, busy low after CFG_APPLY.
- Normal run: shot_count=3, res_ready=1, three triggers each followed by iq_valid 20 cycles later with i=100..102, q=-5..-3:
  - 3 timing_trigger pulses.
  - res_shot 0,1,2 with matching i/q.
  - done pulse after the third iq_valid; shots_done=3; no error flags.
- Backpressure and overflow: FIFO_DEPTH=4, res_ready=0, shot_count=6:
  - First 4 results buffered, shots 4 and 5 dropped; overflow_err=1, shots_done=6.
  - Then res_ready=1 -> shots 0..3 emerge in order.
- Timeout: shot_count=2, one trigger, no iq_valid -> timeout_err=1 at cycle TIMEOUT_CYCLES after timing_trigger; done pulse; shots_done=0.
- Spurious inputs: trigger in IDLE and MEASURE, iq_valid in WAIT_TRIG -> no timing_trigger, no FIFO push. arm with shot_count=0 -> done 1 cycle later, no trigger forwarded.
- Abort and reset: abort during MEASURE after 1 of 4 shots -> done next cycle, shots_done=1, FIFO keeps 1 entry. Repeat the run with reset instead of abort -> all outputs 0, no done pulse, res_valid=0.

Source files
------------

// File: rtl/readout_pkg.sv
// Shared types and widths for the qubit readout run sequencer and its result FIFO.
package readout_pkg;

    localparam int SHOT_W = 16;
    localparam int IQ_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CFG_APPLY = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_FINISH    = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic [IQ_W-1:0]   i;
        logic [IQ_W-1:0]   q;
        logic [SHOT_W-1:0] shot;
    } result_t;

endpackage

// File: rtl/readout_sequencer_fifo.sv
// First-word fall-through result buffer; a push into a full FIFO is dropped unless a pop frees a slot.
module result_fifo
    import readout_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk100,
    input  logic    reset,
    input  logic    push_i,
    input  result_t push_data_i,
    output logic    full_o,
    input  logic    pop_i,
    output logic    valid_o,
    output result_t head_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    result_t          mem_q [DEPTH];
    logic             do_push_s;
    logic             do_pop_s;

    assign valid_o   = (count_q != {(PTR_W+1){1'b0}});
    assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
    assign do_pop_s  = pop_i & valid_o;
    assign do_push_s = push_i & (~full_o | do_pop_s);
    assign head_o    = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk100) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; valid_o masks stale entries.
    always_ff @(posedge clk100) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/readout_sequencer.sv
// Run-level controller for the readout chain: config gating, per-shot trigger forwarding,
// result collection with timeout, and a buffered valid/ready result stream.
module readout_sequencer
    import readout_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16384
) (
    input  logic        clk100,
    input  logic        reset,
    input  logic        arm,
    input  logic        abort,
    input  logic [15:0] shot_count,
    input  logic        cfg_req,
    output logic        cfg_ack,
    output logic        config_reset,
    input  logic        trigger,
    output logic        timing_trigger,
    input  logic        iq_valid,
    input  logic [31:0] i_val,
    input  logic [31:0] q_val,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_i,
    output logic [31:0] res_q,
    output logic [15:0] res_shot,
    output logic        busy,
    output logic        done,
    output logic [15:0] shots_done,
    output logic        overflow_err,
    output logic        timeout_err
);
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    seq_state_t        state_q, state_d;
    logic [SHOT_W-1:0] target_q, target_d;
    logic [SHOT_W-1:0] shots_q, shots_d, shots_inc_s;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              ovf_q, ovf_d;
    logic              tout_q, tout_d;
    logic              trig_fwd_q, trig_fwd_d;
    logic              cfg_pulse_q, done_q, busy_q;
    logic              fifo_full_s, fifo_valid_s, fifo_pop_s, fifo_push_s;
    result_t           fifo_head_s, push_data_s;

    assign shots_inc_s = shots_q + 16'd1;
    assign fifo_pop_s  = fifo_valid_s & res_ready;
    assign push_data_s = '{i: i_val, q: q_val, shot: shots_q};

    // Run state machine and its per-run bookkeeping.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        shots_d     = shots_q;
        to_cnt_d    = to_cnt_q;
        ovf_d       = ovf_q;
        tout_d      = tout_q;
        trig_fwd_d  = 1'b0;
        fifo_push_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_req) begin
                    state_d = ST_CFG_APPLY;
                end else if (arm) begin
                    target_d = shot_count;
                    shots_d  = 16'd0;
                    ovf_d    = 1'b0;
                    tout_d   = 1'b0;
                    state_d  = (shot_count == 16'd0) ? ST_FINISH : ST_WAIT_TRIG;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CFG_APPLY: begin
                state_d = ST_IDLE;
            end
            ST_WAIT_TRIG: begin
                if (abort) begin
                    state_d = ST_FINISH;
                end else if (trigger) begin
                    trig_fwd_d = 1'b1;
                    to_cnt_d   = {TO_W{1'b0}};
                    state_d    = ST_MEASURE;
                end else begin
                    state_d = ST_WAIT_TRIG;
                end
            end
            ST_MEASURE: begin
                if (abort) begin
                    state_d = ST_FINISH;
                end else if (iq_valid) begin
                    // The shot counts as done even if its result is dropped.
                    fifo_push_s = 1'b1;
                    shots_d     = shots_inc_s;
                    if (fifo_full_s && !fifo_pop_s) begin
                        ovf_d = 1'b1;
                    end else begin
                        ovf_d = ovf_q;
                    end
                    state_d = (shots_inc_s == target_q) ? ST_FINISH : ST_WAIT_TRIG;
                end else if (to_cnt_q == TO_LAST) begin
                    tout_d  = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered strobes derived from the next state.
    always_ff @(posedge clk100) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            target_q    <= 16'd0;
            shots_q     <= 16'd0;
            to_cnt_q    <= {TO_W{1'b0}};
            ovf_q       <= 1'b0;
            tout_q      <= 1'b0;
            trig_fwd_q  <= 1'b0;
            cfg_pulse_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            shots_q     <= shots_d;
            to_cnt_q    <= to_cnt_d;
            ovf_q       <= ovf_d;
            tout_q      <= tout_d;
            trig_fwd_q  <= trig_fwd_d;
            cfg_pulse_q <= (state_d == ST_CFG_APPLY);
            done_q      <= (state_d == ST_FINISH);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    result_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk100     (clk100),
        .reset      (reset),
        .push_i     (fifo_push_s),
        .push_data_i(push_data_s),
        .full_o     (fifo_full_s),
        .pop_i      (fifo_pop_s),
        .valid_o    (fifo_valid_s),
        .head_o     (fifo_head_s)
    );

    assign cfg_ack        = cfg_pulse_q;
    assign config_reset   = cfg_pulse_q;
    assign timing_trigger = trig_fwd_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign shots_done     = shots_q;
    assign overflow_err   = ovf_q;
    assign timeout_err    = tout_q;
    assign res_valid      = fifo_valid_s;
    assign res_i          = fifo_valid_s ? fifo_head_s.i    : 32'd0;
    assign res_q          = fifo_valid_s ? fifo_head_s.q    : 32'd0;
    assign res_shot       = fifo_valid_s ? fifo_head_s.shot : 16'd0;

endmodule

// File: tb/tb_readout_sequencer.sv
// Scoreboard bench for readout_sequencer: a queue model of the result buffer plus pulse counters.
module tb_readout_sequencer;

    localparam int DEPTH = 4;
    localparam int TOUT  = 16384;

    logic        clk100 = 1'b0;
    logic        reset, arm, abort, cfg_req, trigger, iq_valid, res_ready;
    logic [15:0] shot_count;
    logic [31:0] i_val, q_val;
    logic        cfg_ack, config_reset, timing_trigger, res_valid, busy, done;
    logic        overflow_err, timeout_err;
    logic [31:0] res_i, res_q;
    logic [15:0] res_shot, shots_done;

    typedef struct {
        logic [31:0] i;
        logic [31:0] q;
        logic [15:0] shot;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   model_shots = 0;
    bit   model_ovf = 1'b0;
    bit   iq_counts = 1'b0;
    bit   arm_counts = 1'b0;
    bit   rnd_ready = 1'b0;
    int   trig_cnt = 0;
    int   done_cnt = 0;
    int   exp_trig = 0;
    int   exp_done = 0;

    readout_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk100(clk100), .reset(reset), .arm(arm), .abort(abort),
        .shot_count(shot_count), .cfg_req(cfg_req), .cfg_ack(cfg_ack),
        .config_reset(config_reset), .trigger(trigger), .timing_trigger(timing_trigger),
        .iq_valid(iq_valid), .i_val(i_val), .q_val(q_val), .res_valid(res_valid),
        .res_ready(res_ready), .res_i(res_i), .res_q(res_q), .res_shot(res_shot),
        .busy(busy), .done(done), .shots_done(shots_done),
        .overflow_err(overflow_err), .timeout_err(timeout_err)
    );

    always #5 clk100 = ~clk100;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: shots taken in MEASURE enter a bounded queue, drained whenever ready is high.
    always @(posedge clk100) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (res_ready && sb.size() > 0) sb.delete(0);
            if (arm_counts) begin
                model_shots = 0;
                model_ovf   = 1'b0;
            end
            if (iq_valid && iq_counts) begin
                if (sb.size() < DEPTH) sb.push_back('{i: i_val, q: q_val, shot: 16'(model_shots)});
                else model_ovf = 1'b1;
                model_shots++;
            end
        end
    end

    // Monitor: compare the presented head against the scoreboard and count pulses.
    always @(negedge clk100) begin
        if (timing_trigger === 1'b1) trig_cnt++;
        if (done === 1'b1) done_cnt++;
        if (sb.size() > 0) begin
            chk("res_valid", res_valid, 1);
            chk("res_i", res_i, sb[0].i);
            chk("res_q", res_q, sb[0].q);
            chk("res_shot", res_shot, sb[0].shot);
        end else begin
            chk("res_valid_empty", res_valid, 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk100);
            #1;
            if (rnd_ready) res_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic start_run(input logic [15:0] n);
        shot_count = n; arm = 1'b1; arm_counts = 1'b1;
        tick(1);
        arm = 1'b0; arm_counts = 1'b0;
        if (n == 16'd0) exp_done++;
    endtask

    task automatic shot(input logic [31:0] iv, input logic [31:0] qv, input int dly, input bit last);
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0; exp_trig++;
        chk("timing_trigger_pulse", timing_trigger, 1);
        tick(1);
        chk("timing_trigger_width", timing_trigger, 0);
        tick(dly);
        i_val = iv; q_val = qv; iq_valid = 1'b1; iq_counts = 1'b1;
        tick(1);
        iq_valid = 1'b0; iq_counts = 1'b0;
        chk("done_after_shot", done, {63'd0, last});
        if (last) exp_done++;
    endtask

    task automatic end_checks(input int n, input bit ovf, input bit tout);
        chk("busy_end", busy, 0);
        chk("shots_done", shots_done, n);
        chk("overflow_err", overflow_err, ovf);
        chk("timeout_err", timeout_err, tout);
        chk("trigger_count", trig_cnt, exp_trig);
        chk("done_count", done_cnt, exp_done);
    endtask

    task automatic drain();
        res_ready = 1'b1;
        for (int k = 0; k < 40 && sb.size() != 0; k++) tick(1);
        tick(1);
        chk("drained", res_valid, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_outs"}, {cfg_ack, config_reset, timing_trigger, res_valid, busy, done,
                             overflow_err, timeout_err}, 0);
        chk({tag, "_shots"}, shots_done, 0);
        chk({tag, "_res"}, {res_i, res_q, res_shot}, 0);
    endtask

    initial begin
        int n;
        reset = 1'b1; arm = 1'b0; abort = 1'b0; cfg_req = 1'b0; trigger = 1'b0;
        iq_valid = 1'b0; res_ready = 1'b0; shot_count = 16'd0; i_val = 32'd0; q_val = 32'd0;
        tick(3);
        check_all_zero("reset");
        reset = 1'b0;
        tick(1);

        // Config apply in IDLE, then cfg_req together with arm.
        cfg_req = 1'b1; tick(1); cfg_req = 1'b0;
        chk("cfg_ack_pulse", {cfg_ack, config_reset, busy}, 3'b111);
        tick(1);
        chk("cfg_ack_width", {cfg_ack, config_reset, busy}, 3'b000);
        cfg_req = 1'b1; arm = 1'b1; shot_count = 16'd5; tick(1); cfg_req = 1'b0; arm = 1'b0;
        chk("cfg_over_arm", cfg_ack, 1);
        tick(1);
        chk("arm_ignored_busy", busy, 0);
        trigger = 1'b1; tick(1); trigger = 1'b0; tick(2);
        chk("trigger_in_idle", trig_cnt, exp_trig);

        // Normal run of three shots.
        res_ready = 1'b1;
        start_run(16'd3);
        for (int k = 0; k < 3; k++) shot(32'(100 + k), 32'(-5 + k), 20, k == 2);
        tick(1);
        end_checks(3, 1'b0, 1'b0);

        // Backpressure: six shots into a four-deep buffer.
        res_ready = 1'b0;
        start_run(16'd6);
        for (int k = 0; k < 6; k++) shot($urandom, $urandom, $urandom_range(0, 5), k == 5);
        tick(1);
        end_checks(6, 1'b1, 1'b0);
        drain();

        // Timeout: one trigger, no result.
        start_run(16'd2);
        trigger = 1'b1; tick(1); trigger = 1'b0; exp_trig++;
        chk("to_trigger", timing_trigger, 1);
        tick(TOUT - 1);
        chk("to_early", {timeout_err, done}, 2'b00);
        tick(1);
        chk("to_fire", {timeout_err, done}, 2'b11);
        exp_done++;
        tick(1);
        end_checks(0, 1'b0, 1'b1);

        // Spurious iq_valid in WAIT_TRIG and trigger in MEASURE.
        start_run(16'd1);
        i_val = 32'hDEAD_BEEF; iq_valid = 1'b1; tick(1); iq_valid = 1'b0;
        tick(1);
        chk("iq_in_wait", res_valid, 0);
        trigger = 1'b1; tick(1); trigger = 1'b0; exp_trig++;
        tick(2);
        trigger = 1'b1; tick(1); trigger = 1'b0; tick(2);
        chk("trigger_in_measure", trig_cnt, exp_trig);
        i_val = 32'h1234_5678; q_val = 32'h0BAD_F00D; iq_valid = 1'b1; iq_counts = 1'b1;
        tick(1);
        iq_valid = 1'b0; iq_counts = 1'b0; exp_done++;
        chk("spurious_done", done, 1);
        tick(1);
        end_checks(1, 1'b0, 1'b0);

        // Zero-shot run finishes immediately.
        start_run(16'd0);
        chk("zero_run_done", {done, busy}, 2'b11);
        tick(1);
        end_checks(0, 1'b0, 1'b0);

        // Abort mid-measure after one of four shots.
        res_ready = 1'b0;
        start_run(16'd4);
        shot(32'h0000_00AA, 32'h0000_00BB, 3, 1'b0);
        trigger = 1'b1; tick(1); trigger = 1'b0; exp_trig++;
        tick(3);
        abort = 1'b1; tick(1); abort = 1'b0; exp_done++;
        chk("abort_done", {done, shots_done}, {1'b1, 16'd1});
        tick(1);
        end_checks(1, 1'b0, 1'b0);
        chk("abort_keeps_fifo", res_valid, 1);
        drain();

        // Reset mid-run: flush and no done pulse.
        res_ready = 1'b0;
        start_run(16'd4);
        shot(32'h0000_0011, 32'h0000_0022, 2, 1'b0);
        trigger = 1'b1; tick(1); trigger = 1'b0; exp_trig++;
        tick(2);
        reset = 1'b1; tick(1);
        check_all_zero("midrun_reset");
        reset = 1'b0; tick(2);
        chk("reset_no_done", done_cnt, exp_done);

        // Randomized runs with random backpressure.
        rnd_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 8);
            start_run(16'(n));
            for (int k = 0; k < n; k++) shot($urandom, $urandom, $urandom_range(0, 25), k == n - 1);
            tick(1);
            end_checks(n, model_ovf, 1'b0);
        end
        rnd_ready = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
